seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Parametrised time-multiplexed seven-segment display driver for the board's common-anode display bank. It replaces the single-digit, always-on decode path with a scanning controller that drives NUM_DIGITS digits from one shared segment bus. It supports per-digit enable, per-digit decimal point and leading-zero suppression. A shadow-register load handshake guarantees that a displayed frame never mixes old and new data. It sits between the switch/push-button input logic and the display pins.

## Interface
- NUM_DIGITS, 8, number of digits scanned (1..16); digit 0 is rightmost.
- TICKS_PER_DIGIT, 100000, clock cycles each digit slot lasts (>= 2).
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- data_in  in  4*NUM_DIGITS  hex nibble per digit; digit i at [4i+3:4i].
- dp_in  in  NUM_DIGITS  decimal-point request per digit, active-high.
- digit_en  in  NUM_DIGITS  1 = digit displayed, 0 = digit fully dark (segments and dp).
- blank_zeros  in  1  leading-zero suppression mode.
- load  in  1  single-cycle request to capture data_in, dp_in, digit_en, blank_zeros.
- load_ack  out  1  one-cycle pulse: new frame data now active.
- seg  out  7  segments {a,b,c,d,e,f,g} = seg[6:0], active-low.
- dp  out  1  decimal point, active-low.
- anode  out  NUM_DIGITS  digit select, active-low, one-hot-low or all-ones.

## Operation
- Three register sets: pending (captured on load), active (drives display), scan state (tick_cnt 0..TICKS_PER_DIGIT-1, idx 0..NUM_DIGITS-1, width max(1,clog2(NUM_DIGITS))).
- load=1: pending takes all four inputs and pending_valid is set. A load while pending_valid=1 overwrites the pending contents; the latest load wins.
- tick_cnt increments every cycle. When tick_cnt = TICKS_PER_DIGIT-1, tick_cnt goes to 0 and idx increments, wrapping from NUM_DIGITS-1 to 0.
- Frame boundary is the cycle where idx wraps. At that boundary:
  - If pending_valid=1, active takes pending and pending_valid clears.
  - load_ack pulses in the next cycle.
  - If load occurs in the boundary cycle itself, the transfer uses the pre-load pending contents, and the new load is held pending (pending_valid stays 1).
- With NUM_DIGITS=1, every slot end is a frame boundary.
- Leading-zero suppression: if active blank_zeros=1, digit i>0 is blanked when active nibbles i..NUM_DIGITS-1 are all 0. Digit 0 is never zero-blanked. A zero-blanked digit still shows its dp if enabled.
- Hex decode, seg[6:0] active-low: 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000.
- Output register (seg, dp, anode) is loaded every cycle:
  - If tick_cnt = 0 (dead-time cycle), anode is all ones, and seg and dp are all ones.
  - Otherwise, anode[idx]=0 and all other anode bits are 1. seg is the decode of active nibble idx, or all ones if the digit is disabled or zero-blanked. dp = ~(dp_active[idx] & en_active[idx]).
- Reset values: tick_cnt=0, idx=0, pending and active all zero, pending_valid=0, anode all ones, seg=7'b1111111, dp=1, load_ack=0. Display is dark until the first load has been transferred.
- Reset asserted mid-frame: all registers and outputs go to reset values immediately, without waiting for a clock. Scan restarts at idx 0 on the first edge after deassertion.

## Timing
- Outputs are registered, with one cycle of latency from tick_cnt/idx/active state.
- Per slot: 1 dead cycle followed by TICKS_PER_DIGIT-1 cycles of digit drive. Frame length is NUM_DIGITS*TICKS_PER_DIGIT cycles.
- The load-to-display bound covers the full path from load to visible data:
  - From load to the active update: at most NUM_DIGITS*TICKS_PER_DIGIT cycles.
  - load_ack follows 1 cycle after the active update.
  - The first visible digit appears 2 cycles after the active update.
- At most one anode is low in any cycle. Anode never switches directly from one low digit to another.

## Test plan
- Setup: NUM_DIGITS=4, TICKS_PER_DIGIT=4. Reset, then load data_in=16'h12AF, digit_en=4'hF, dp_in=0. Required response: load_ack one cycle after the first wrap. anode then cycles 1111,1110,1110,1110 / 1111,1101,... with seg 0111000 (F), 0001000 (A), 0010010 (2), 1001111 (1).
- Load 16'h0050 with blank_zeros=1. Required response: digits 3 and 2 dark (seg=1111111 while their anode is low), digit 1 shows 5, digit 0 shows 0.
- Load 16'h0000 with blank_zeros=1 and dp_in=4'b0100. Required response: only digit 0 shows 0, and digit 2 shows dp=0 with seg dark.
- Two loads within one frame (16'h1111, then 16'h2222), plus a third load exactly on the boundary cycle. Required response: active becomes 2222 with one load_ack. The third value appears one frame later with a second load_ack.
- digit_en=4'b1010 with dp_in=4'hF. Required response: digits 0 and 2 keep seg and dp high in every slot.
- Assert rst_n=0 mid-slot. Required response: anode, seg and dp go to all ones with no clock edge. After release, the scan restarts at idx 0 and the display stays dark until a new load.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with double-buffered frame data,
// per-digit enable/decimal point and leading-zero suppression.
module seg7_scan_driver #(
    parameter int NUM_DIGITS      = 8,
    parameter int TICKS_PER_DIGIT = 100000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   data_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic                      blank_zeros,
    input  logic                      load,
    output logic                      load_ack,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     anode
);

    localparam int TW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_DIGIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            4'hF:    s = 7'b0111000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [TW-1:0]           tick_cnt_r;
    logic [IW-1:0]           idx_r;
    logic [4*NUM_DIGITS-1:0] pend_data_r, act_data_r;
    logic [NUM_DIGITS-1:0]   pend_dp_r, pend_en_r, act_dp_r, act_en_r;
    logic                    pend_bz_r, act_bz_r, pend_valid_r;
    logic                    load_ack_r, dp_r;
    logic [6:0]              seg_r;
    logic [NUM_DIGITS-1:0]   anode_r;

    logic                    slot_end_s, frame_end_s, zero_above_s;
    logic [NUM_DIGITS-1:0]   zblank_s, anode_s;
    logic [6:0]              seg_s;
    logic                    dp_s;

    assign slot_end_s  = (tick_cnt_r == TICK_LAST);
    assign frame_end_s = slot_end_s && (idx_r == IDX_LAST);

    // Scan position: tick within the slot and the digit being driven.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_r <= {TW{1'b0}};
            idx_r      <= {IW{1'b0}};
        end else if (slot_end_s) begin
            tick_cnt_r <= {TW{1'b0}};
            idx_r      <= (idx_r == IDX_LAST) ? {IW{1'b0}} : idx_r + IW'(1);
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    // Pending shadow set; a load on the boundary cycle stays pending for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_data_r  <= {(4*NUM_DIGITS){1'b0}};
            pend_dp_r    <= {NUM_DIGITS{1'b0}};
            pend_en_r    <= {NUM_DIGITS{1'b0}};
            pend_bz_r    <= 1'b0;
            pend_valid_r <= 1'b0;
        end else if (load) begin
            pend_data_r  <= data_in;
            pend_dp_r    <= dp_in;
            pend_en_r    <= digit_en;
            pend_bz_r    <= blank_zeros;
            pend_valid_r <= 1'b1;
        end else if (frame_end_s) begin
            pend_valid_r <= 1'b0;
        end
    end

    // Active set only changes at the frame boundary so a frame never mixes data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_data_r <= {(4*NUM_DIGITS){1'b0}};
            act_dp_r   <= {NUM_DIGITS{1'b0}};
            act_en_r   <= {NUM_DIGITS{1'b0}};
            act_bz_r   <= 1'b0;
            load_ack_r <= 1'b0;
        end else begin
            if (frame_end_s && pend_valid_r) begin
                act_data_r <= pend_data_r;
                act_dp_r   <= pend_dp_r;
                act_en_r   <= pend_en_r;
                act_bz_r   <= pend_bz_r;
            end
            load_ack_r <= frame_end_s && pend_valid_r;
        end
    end

    // Leading-zero mask: digit i blanks when it and every higher nibble are zero.
    always_comb begin
        zblank_s     = {NUM_DIGITS{1'b0}};
        zero_above_s = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above_s = zero_above_s & (act_data_r[4*i +: 4] == 4'h0);
            zblank_s[i]  = act_bz_r & zero_above_s & (i != 0);
        end
    end

    // Next output values; tick 0 is the dead time between digits.
    always_comb begin
        seg_s   = 7'b1111111;
        dp_s    = 1'b1;
        anode_s = {NUM_DIGITS{1'b1}};
        if (tick_cnt_r != {TW{1'b0}}) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                anode_s[i] = (idx_r != IW'(i));
            end
            seg_s = (act_en_r[idx_r] && !zblank_s[idx_r])
                    ? hex_decode(act_data_r[{idx_r, 2'b00} +: 4]) : 7'b1111111;
            dp_s  = ~(act_dp_r[idx_r] & act_en_r[idx_r]);
        end else begin
            seg_s   = 7'b1111111;
            dp_s    = 1'b1;
            anode_s = {NUM_DIGITS{1'b1}};
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r   <= 7'b1111111;
            dp_r    <= 1'b1;
            anode_r <= {NUM_DIGITS{1'b1}};
        end else begin
            seg_r   <= seg_s;
            dp_r    <= dp_s;
            anode_r <= anode_s;
        end
    end

    assign seg      = seg_r;
    assign dp       = dp_r;
    assign anode    = anode_r;
    assign load_ack = load_ack_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed table, boundary sequences, reset and
// randomized traffic against a frame-position reference model.
module tb_seg7_scan_driver;
    localparam int N = 4;
    localparam int T = 4;
    localparam int F = N * T;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] data_in = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  digit_en = 4'h0;
    logic        blank_zeros = 1'b0;
    logic        load = 1'b0;
    logic        load_ack;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  anode;

    seg7_scan_driver #(.NUM_DIGITS(N), .TICKS_PER_DIGIT(T)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in),
        .digit_en(digit_en), .blank_zeros(blank_zeros), .load(load),
        .load_ack(load_ack), .seg(seg), .dp(dp), .anode(anode)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dpv;
        logic [3:0]  en;
        logic        bz;
        logic [27:0] exp_seg;   // {digit3, digit2, digit1, digit0}
        logic [3:0]  exp_dp;
    } vec_t;
    vec_t tbl [4];

    int checks = 0;
    int failures = 0;

    // Reference model state: frame position n and the pending/active data sets.
    int          n;
    logic [15:0] a_data, p_data;
    logic [3:0]  a_dp, a_en, p_dp, p_en, m_anode, prev_anode;
    logic        a_bz, p_bz, pv, m_dp, m_ack;
    logic [6:0]  m_seg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %h expected %h (n=%0d, t=%0t)", name, act, exp, n, $time);
        end
    endtask

    task automatic model_reset();
        a_data = 16'h0; p_data = 16'h0; a_dp = 4'h0; a_en = 4'h0; p_dp = 4'h0; p_en = 4'h0;
        a_bz = 1'b0; p_bz = 1'b0; pv = 1'b0; n = 0;
        m_seg = 7'h7F; m_dp = 1'b1; m_anode = 4'hF; m_ack = 1'b0; prev_anode = 4'hF;
    endtask

    task automatic step();
        int tick, pos;
        logic boundary, blank, ok;
        logic [15:0] sh;
        @(posedge clk);
        tick = n % T;
        pos  = (n / T) % N;
        boundary = ((n % F) == F - 1);
        if (tick == 0) begin
            m_anode = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
        end else begin
            m_anode = 4'hF;
            m_anode[pos] = 1'b0;
            sh = a_data >> (4 * pos);
            blank = a_bz && (pos > 0) && (sh == 16'h0);
            m_seg = (a_en[pos] && !blank) ? hex_tab[sh[3:0]] : 7'h7F;
            m_dp = ~(a_dp[pos] & a_en[pos]);
        end
        m_ack = boundary && pv;
        if (boundary && pv) begin
            a_data = p_data; a_dp = p_dp; a_en = p_en; a_bz = p_bz; pv = 1'b0;
        end
        if (load) begin
            p_data = data_in; p_dp = dp_in; p_en = digit_en; p_bz = blank_zeros; pv = 1'b1;
        end
        n++;
        #1;
        load = 1'b0;
        check("seg", seg, m_seg);
        check("dp", dp, m_dp);
        check("anode", anode, m_anode);
        check("load_ack", load_ack, m_ack);
        ok = ($countones(~anode) <= 1) &&
             !(prev_anode != 4'hF && anode != 4'hF && anode != prev_anode);
        check("anode_safe", ok, 1'b1);
        prev_anode = anode;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dpv,
                           input logic [3:0] en, input logic bz);
        data_in = d; dp_in = dpv; digit_en = en; blank_zeros = bz; load = 1'b1;
        step();
    endtask

    task automatic wait_phase(input int p);
        for (int k = 0; k < 2 * F && (n % F) != p; k++) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic got;
        int   d, acks;

        tbl[0] = '{16'h12AF, 4'h0, 4'hF, 1'b0,
                   {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000}, 4'hF};
        tbl[1] = '{16'h0050, 4'h0, 4'hF, 1'b1,
                   {7'b1111111, 7'b1111111, 7'b0100100, 7'b0000001}, 4'hF};
        tbl[2] = '{16'h0000, 4'b0100, 4'hF, 1'b1,
                   {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'b1011};
        tbl[3] = '{16'h8888, 4'hF, 4'b1010, 1'b0,
                   {7'b0000000, 7'b1111111, 7'b0000000, 7'b1111111}, 4'b0101};

        model_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_anode", anode, 4'hF);
        check("rst_ack", load_ack, 1'b0);
        rst_n = 1'b1;

        repeat (2 * F) step();   // dark before any load

        for (int e = 0; e < 4; e++) begin
            do_load(tbl[e].data, tbl[e].dpv, tbl[e].en, tbl[e].bz);
            got = 1'b0;
            for (int k = 0; k < F + 2 && !got; k++) begin
                step();
                if (load_ack) got = 1'b1;
            end
            check("tbl_ack_seen", got, 1'b1);
            for (int k = 0; k < F; k++) begin
                step();
                if (anode != 4'hF) begin
                    d = 0;
                    for (int i = 0; i < N; i++) if (!anode[i]) d = i;
                    check("tbl_seg", seg, tbl[e].exp_seg[7*d +: 7]);
                    check("tbl_dp", dp, tbl[e].exp_dp[d]);
                end
            end
        end

        // Two loads in one frame, third on the boundary cycle itself.
        wait_phase(1);
        do_load(16'h1111, 4'h0, 4'hF, 1'b0);
        step();
        do_load(16'h2222, 4'h0, 4'hF, 1'b0);
        wait_phase(F - 1);
        do_load(16'h3333, 4'h0, 4'hF, 1'b0);
        check("ack_at_boundary", load_ack, 1'b1);
        step();
        step();
        check("show_2222_seg", seg, 7'b0010010);
        check("show_2222_anode", anode, 4'b1110);
        acks = 0;
        for (int k = 0; k < F; k++) begin
            step();
            if (load_ack) acks++;
        end
        check("second_ack_count", acks, 1);
        check("show_3333_seg", seg, 7'b0000110);

        // Asynchronous reset in the middle of a lit slot.
        wait_phase(6);
        step();
        check("pre_reset_lit", anode, 4'b1101);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_anode", anode, 4'hF);
        check("async_rst_seg", seg, 7'h7F);
        check("async_rst_dp", dp, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        step();
        step();
        check("restart_idx0", anode, 4'b1110);
        check("restart_dark", seg, 7'h7F);
        repeat (2 * F) step();

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            data_in = 16'($urandom);
            for (int j = 0; j < 4; j++) if ($urandom_range(0, 1) == 0) data_in[4*j +: 4] = 4'h0;
            dp_in = 4'($urandom);
            digit_en = 4'($urandom);
            blank_zeros = 1'($urandom);
            load = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
